// File: rtl/fe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : fe_pkg                                                     |
// | Shared fetch-engine widths and the instruction-queue entry type.     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package fe_pkg;

  localparam int XLEN           = 32;
  localparam int LINE_W         = 128;
  localparam int INSTS_PER_LINE = 4;

  // One queued instruction together with the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage : fe_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fetch_fifo                                                 |
// | Circular buffer of fetch entries: up to four writes, one read per    |
// | cycle. Entries wr_data_i[0..wr_n_i-1] land at tail, tail+1, ...      |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module fetch_fifo
  import fe_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    clr_i,
  input  logic [2:0]                              wr_n_i,
  input  fetch_entry_t [INSTS_PER_LINE-1:0]       wr_data_i,
  input  logic                                    rd_en_i,
  output fetch_entry_t                            rd_data_o,
  output logic [$clog2(DEPTH):0]                  count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t        mem_q [DEPTH];
  logic [AW-1:0]       head_q;
  logic [AW-1:0]       tail_q;
  logic [CW-1:0]       count_q;

  // Storage write: consecutive slots from tail; pointer arithmetic wraps at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst && !clr_i) begin
      for (int i = 0; i < INSTS_PER_LINE; i++) begin
        if (3'(i) < wr_n_i) begin
          mem_q[tail_q + AW'(i)] <= wr_data_i[i];
        end
      end
    end
  end

  // Pointer and occupancy update; reset and clear both empty the buffer.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + AW'(rd_en_i);
      tail_q  <= tail_q + AW'(wr_n_i);
      count_q <= count_q + CW'(wr_n_i) - CW'(rd_en_i);
    end
  end

  assign rd_data_o = mem_q[head_q];
  assign count_o   = count_q;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fetch_queue                                                |
// | Instruction fetch front end: reads one ROM line per cycle from the   |
// | current PC, enqueues the valid words of that line all-or-nothing,    |
// | and presents the oldest instruction to the consumer.                 |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module fetch_queue
  import fe_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [XLEN-1:0]         rom_addr,
  input  logic [LINE_W-1:0]       rom_data,
  input  logic                    flush,
  input  logic [XLEN-1:0]         flush_pc,
  output logic                    deq_valid,
  input  logic                    deq_ready,
  output logic [XLEN-1:0]         deq_inst,
  output logic [XLEN-1:0]         deq_pc,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]                    pc_q;
  logic [XLEN-1:0]                    pc_d;
  logic [2:0]                         w_n_new;
  logic [CW-1:0]                      w_free;
  logic                               w_enq;
  logic                               w_deq;
  logic [2:0]                         w_wr_n;
  fetch_entry_t [INSTS_PER_LINE-1:0]  w_entries;
  fetch_entry_t                       w_head;
  logic [1:0]                         w_flush_lo_unused;

  // Redirect targets are word aligned; the low bits are dropped.
  assign w_flush_lo_unused = flush_pc[1:0];

  assign rom_addr = pc_q;

  // Words from the PC's offset up to the end of the line are usable.
  assign w_n_new = 3'd4 - {1'b0, pc_q[3:2]};
  // Free space uses the occupancy before this cycle's dequeue.
  assign w_free  = CW'(DEPTH) - count;
  assign w_enq   = !flush && (w_free >= CW'(w_n_new));
  assign w_deq   = deq_valid && deq_ready && !flush;
  assign w_wr_n  = w_enq ? w_n_new : 3'd0;

  // Reorder the line so the word at the PC offset is entry 0; tags carry each word's address.
  always_comb begin
    w_entries = '0;
    for (int i = 0; i < INSTS_PER_LINE; i++) begin
      w_entries[i].pc   = {pc_q[31:4], pc_q[3:2] + 2'(i), 2'b00};
      w_entries[i].inst = rom_data[{pc_q[3:2] + 2'(i), 5'b00000} +: XLEN];
    end
  end

  // Next fetch PC: redirect wins, otherwise step to the next line after a successful enqueue.
  always_comb begin
    pc_d = pc_q;
    if (flush) begin
      pc_d = {flush_pc[31:2], 2'b00};
    end else if (w_enq) begin
      pc_d = {pc_q[31:4] + 28'd1, 4'b0000};
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (flush),
    .wr_n_i    (w_wr_n),
    .wr_data_i (w_entries),
    .rd_en_i   (w_deq),
    .rd_data_o (w_head),
    .count_o   (count)
  );

  assign deq_valid = (count != '0);
  assign deq_inst  = w_head.inst;
  assign deq_pc    = w_head.pc;

endmodule : fetch_queue
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_fetch_queue                                             |
// | Directed vector table plus a random-backpressure scoreboard run for  |
// | the instruction fetch queue, with a behavioural ROM.                 |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_fetch_queue;

  logic         clk;
  logic         rst;
  logic [31:0]  rom_addr;
  logic [127:0] rom_data;
  logic         flush;
  logic [31:0]  flush_pc;
  logic         deq_valid;
  logic         deq_ready;
  logic [31:0]  deq_inst;
  logic [31:0]  deq_pc;
  logic [3:0]   count;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_queue #(
    .DEPTH    (8),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .flush     (flush),
    .flush_pc  (flush_pc),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_inst  (deq_inst),
    .deq_pc    (deq_pc),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: the word at byte address A holds 32'h1000_0000 + A/4.
  always_comb begin
    rom_data = '0;
    for (int k = 0; k < 4; k++) begin
      rom_data[k*32 +: 32] = 32'h1000_0000 + {4'b0, rom_addr[31:4], 2'(k)};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        flush;
    logic [31:0] fpc;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [3:0]  e_count;
    logic [31:0] e_addr;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic f, input logic [31:0] fp, input logic rd,
                              input logic ev, input logic [31:0] epc, input logic [31:0] ei,
                              input logic [3:0] ec, input logic [31:0] ea);
    vec_t v;
    v.rst = r; v.flush = f; v.fpc = fp; v.rdy = rd;
    v.e_valid = ev; v.e_pc = epc; v.e_inst = ei; v.e_count = ec; v.e_addr = ea;
    return v;
  endfunction

  localparam int NV = 20;
  vec_t vt [NV];

  logic [31:0] exp_pc;
  int          n_deq;

  initial begin
    rst = 1'b1; flush = 1'b0; flush_pc = '0; deq_ready = 1'b0;

    //           rst flush fpc            rdy  valid pc            inst           cnt ea
    vt[0]  = mk(1, 0, 32'h0,           0,   0, 32'h0,        32'h0,         0, 32'h00);
    vt[1]  = mk(0, 0, 32'h0,           0,   1, 32'h0,        32'h1000_0000, 4, 32'h10);
    vt[2]  = mk(0, 0, 32'h0,           0,   1, 32'h0,        32'h1000_0000, 8, 32'h20);
    vt[3]  = mk(0, 0, 32'h0,           0,   1, 32'h0,        32'h1000_0000, 8, 32'h20);
    vt[4]  = mk(0, 0, 32'h0,           1,   1, 32'h4,        32'h1000_0001, 7, 32'h20);
    vt[5]  = mk(0, 0, 32'h0,           1,   1, 32'h8,        32'h1000_0002, 6, 32'h20);
    vt[6]  = mk(0, 0, 32'h0,           1,   1, 32'hC,        32'h1000_0003, 5, 32'h20);
    vt[7]  = mk(0, 0, 32'h0,           1,   1, 32'h10,       32'h1000_0004, 4, 32'h20);
    vt[8]  = mk(0, 0, 32'h0,           1,   1, 32'h14,       32'h1000_0005, 7, 32'h30);
    vt[9]  = mk(0, 1, 32'h2B,          1,   0, 32'h0,        32'h0,         0, 32'h28);
    vt[10] = mk(0, 0, 32'h0,           1,   1, 32'h28,       32'h1000_000A, 2, 32'h30);
    vt[11] = mk(0, 0, 32'h0,           1,   1, 32'h2C,       32'h1000_000B, 5, 32'h40);
    vt[12] = mk(1, 1, 32'h80,          1,   0, 32'h0,        32'h0,         0, 32'h00);
    vt[13] = mk(0, 0, 32'h0,           1,   1, 32'h0,        32'h1000_0000, 4, 32'h10);
    vt[14] = mk(0, 0, 32'h0,           1,   1, 32'h4,        32'h1000_0001, 7, 32'h20);
    vt[15] = mk(0, 0, 32'h0,           0,   1, 32'h4,        32'h1000_0001, 7, 32'h20);
    vt[16] = mk(0, 0, 32'h0,           1,   1, 32'h8,        32'h1000_0002, 6, 32'h20);
    vt[17] = mk(0, 0, 32'h0,           1,   1, 32'hC,        32'h1000_0003, 5, 32'h20);
    vt[18] = mk(0, 0, 32'h0,           1,   1, 32'h10,       32'h1000_0004, 4, 32'h20);
    vt[19] = mk(0, 0, 32'h0,           1,   1, 32'h14,       32'h1000_0005, 7, 32'h30);

    // Each vector: drive inputs, one rising edge, then check the resulting state.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = vt[i].rst; flush = vt[i].flush; flush_pc = vt[i].fpc; deq_ready = vt[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.valid", i), {31'b0, deq_valid}, {31'b0, vt[i].e_valid});
      chk($sformatf("v%0d.count", i), {28'b0, count}, {28'b0, vt[i].e_count});
      chk($sformatf("v%0d.rom_addr", i), rom_addr, vt[i].e_addr);
      if (vt[i].e_valid) begin
        chk($sformatf("v%0d.deq_pc", i), deq_pc, vt[i].e_pc);
        chk($sformatf("v%0d.deq_inst", i), deq_inst, vt[i].e_inst);
      end
    end

    // Random backpressure: every accepted head must be the next sequential ROM word.
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; deq_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_pc = 32'h0;
    n_deq  = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      deq_ready = 1'($urandom_range(0, 1));
      chk("rand.count_bound", {31'b0, (count <= 4'd8)}, 32'd1);
      if (deq_valid && deq_ready) begin
        chk($sformatf("rand.pc#%0d", n_deq), deq_pc, exp_pc);
        chk($sformatf("rand.inst#%0d", n_deq), deq_inst, 32'h1000_0000 + {2'b00, exp_pc[31:2]});
        exp_pc = exp_pc + 32'd4;
        n_deq++;
      end
    end
    @(negedge clk);
    deq_ready = 1'b0;
    chk("rand.progress", {31'b0, (n_deq > 200)}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fetch_queue
`default_nettype wire
